// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch-stage PC / branch-redirect controller:
// FSM state encoding, PC increment and default reset PC.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction fetches are word aligned; low address bits are dropped silently.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: increment unless already saturated.
  always_comb begin
    // NOTE: default assignment first so every path writes count_d and no latch is inferred.
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage PC owner and branch-redirect controller.
// Takes the ID-stage branch decision and target, redirects the fetch PC,
// flushes IF/ID, and parks a redirect in PEND while instruction memory is
// busy so the fetch address stays stable during an outstanding request.
// Optional build macro: BRANCH_STATS_EN enables the branch statistics
// counters; without it br_count/taken_count are tied to zero.
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 branch,
  input  logic                 br_inst,
  input  logic [31:0]          target,
  input  logic                 stall,
  input  logic                 imem_ready,
  output logic [31:0]          pc,
  output logic                 fetch_valid,
  output logic                 flush_ifid,
  output logic                 redirect_pending,
  output logic [CNT_WIDTH-1:0] br_count,
  output logic [CNT_WIDTH-1:0] taken_count
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic        fetch_valid_q;
  logic [31:0] pend_target_q;

  // A taken branch only counts when operands are resolved (no stall).
  logic run_active;
  assign run_active = (state_q == ST_RUN) && !stall;

  // Redirect FSM: owns the PC, the fetch-valid flag and the parked target.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      pend_target_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q       <= ST_RUN;
          fetch_valid_q <= 1'b1;
        end
        ST_RUN: begin
          if (stall) begin
            pc_q <= pc_q;
          end else if (branch) begin
            if (imem_ready) begin
              pc_q <= align_word(target);
            end else begin
              pend_target_q <= align_word(target);
              state_q       <= ST_PEND;
            end
          end else if (imem_ready) begin
            pc_q <= pc_q + PC_STEP;
          end
        end
        ST_PEND: begin
          // Address must stay put until memory completes the wrong-path fetch.
          if (imem_ready) begin
            pc_q    <= pend_target_q;
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pc               = pc_q;
  assign fetch_valid      = fetch_valid_q;
  assign redirect_pending = (state_q == ST_PEND);
  // One pulse on the taken branch, one more when a parked redirect lands.
  assign flush_ifid       = (run_active && branch) ||
                            ((state_q == ST_PEND) && imem_ready);

`ifdef BRANCH_STATS_EN
  sat_counter #(.WIDTH(CNT_WIDTH)) u_br_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (run_active && br_inst),
    .count (br_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (run_active && branch),
    .count (taken_count)
  );
`else
  // br_inst only feeds the statistics counters.
  logic unused_br_inst;
  assign unused_br_inst = br_inst;

  assign br_count    = '0;
  assign taken_count = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl. Two instances share stimulus:
// A uses the default reset PC and 16-bit counters, B resets near the top of
// the address space (wrap) and uses 3-bit counters (saturation).
module tb_pc_redirect_ctrl;

`ifdef BRANCH_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  localparam logic [31:0] RST_PC_A = 32'h0000_0000;
  localparam logic [31:0] RST_PC_B = 32'hFFFF_FFF8;
  localparam int          CW_A     = 16;
  localparam int          CW_B     = 3;

  logic        clk;
  logic        rst_n;
  logic        branch;
  logic        br_inst;
  logic [31:0] target;
  logic        stall;
  logic        imem_ready;

  logic [31:0]     pc_a, pc_b;
  logic            fv_a, fv_b, fl_a, fl_b, rp_a, rp_b;
  logic [CW_A-1:0] brc_a, tkc_a;
  logic [CW_B-1:0] brc_b, tkc_b;

  pc_redirect_ctrl #(.RESET_PC(RST_PC_A), .CNT_WIDTH(CW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .branch(branch), .br_inst(br_inst),
    .target(target), .stall(stall), .imem_ready(imem_ready),
    .pc(pc_a), .fetch_valid(fv_a), .flush_ifid(fl_a),
    .redirect_pending(rp_a), .br_count(brc_a), .taken_count(tkc_a)
  );

  pc_redirect_ctrl #(.RESET_PC(RST_PC_B), .CNT_WIDTH(CW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .branch(branch), .br_inst(br_inst),
    .target(target), .stall(stall), .imem_ready(imem_ready),
    .pc(pc_b), .fetch_valid(fv_b), .flush_ifid(fl_b),
    .redirect_pending(rp_b), .br_count(brc_b), .taken_count(tkc_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: a mode word (-1 unknown, 0 idle, 1 running, 2 waiting to
  // redirect) plus the architectural values each instance should show.
  int          m_mode = -1;
  logic [31:0] m_pt;
  logic [31:0] m_pc [2];
  bit          m_fv;
  longint      m_br [2];
  longint      m_tk [2];
  longint      m_max [2];
  logic [31:0] m_rst [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_flush();
    return (m_mode == 1 && !stall && branch) || (m_mode == 2 && imem_ready);
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_mode = 0; m_fv = 1'b0; m_pt = 32'h0;
      for (int i = 0; i < 2; i++) begin
        m_pc[i] = m_rst[i]; m_br[i] = 0; m_tk[i] = 0;
      end
    end else if (m_mode == 0) begin
      m_mode = 1; m_fv = 1'b1;
    end else if (m_mode == 1) begin
      if (!stall) begin
        for (int i = 0; i < 2; i++) begin
          if (br_inst && m_br[i] < m_max[i]) m_br[i]++;
          if (branch  && m_tk[i] < m_max[i]) m_tk[i]++;
        end
        if (branch) begin
          if (imem_ready) begin
            for (int i = 0; i < 2; i++) m_pc[i] = target & ~32'h3;
          end else begin
            m_pt = target & ~32'h3; m_mode = 2;
          end
        end else if (imem_ready) begin
          for (int i = 0; i < 2; i++) m_pc[i] = m_pc[i] + 32'd4;
        end
      end
    end else if (m_mode == 2) begin
      if (imem_ready) begin
        for (int i = 0; i < 2; i++) m_pc[i] = m_pt;
        m_mode = 1;
      end
    end
  endtask

  // One clock: drive inputs, check the combinational flush mid-cycle, then
  // advance the model across the edge and check the registered outputs.
  task automatic cycle(input bit r, input bit b, input bit bi,
                       input logic [31:0] t, input bit s, input bit rdy);
    rst_n = r; branch = b; br_inst = bi | b; target = t; stall = s; imem_ready = rdy;
    #3;
    if (m_mode >= 0) begin
      check("flush_a", {31'b0, fl_a}, {31'b0, exp_flush()});
      check("flush_b", {31'b0, fl_b}, {31'b0, exp_flush()});
    end
    @(posedge clk);
    model_step();
    #1;
    check("pc_a",  pc_a, m_pc[0]);
    check("pc_b",  pc_b, m_pc[1]);
    check("fv_a",  {31'b0, fv_a}, {31'b0, m_fv});
    check("fv_b",  {31'b0, fv_b}, {31'b0, m_fv});
    check("pend_a", {31'b0, rp_a}, {31'b0, m_mode == 2});
    check("pend_b", {31'b0, rp_b}, {31'b0, m_mode == 2});
    check("brc_a", 32'(brc_a), STATS_EN ? 32'(m_br[0]) : 32'h0);
    check("tkc_a", 32'(tkc_a), STATS_EN ? 32'(m_tk[0]) : 32'h0);
    check("brc_b", 32'(brc_b), STATS_EN ? 32'(m_br[1]) : 32'h0);
    check("tkc_b", 32'(tkc_b), STATS_EN ? 32'(m_tk[1]) : 32'h0);
  endtask

  initial begin
    m_rst[0] = RST_PC_A; m_rst[1] = RST_PC_B;
    m_max[0] = (64'd1 << CW_A) - 1; m_max[1] = (64'd1 << CW_B) - 1;
    rst_n = 1'b0; branch = 1'b0; br_inst = 1'b0; target = '0; stall = 1'b0; imem_ready = 1'b0;
    #1;

    // Reset, then three ready cycles: 0 (idle), 0, 4, 8; B wraps through zero.
    cycle(0, 0, 0, 32'h0, 0, 1);
    check("reset_pc_a", pc_a, 32'h0);
    check("reset_fv_a", {31'b0, fv_a}, 32'h0);
    check("reset_pc_b", pc_b, 32'hFFFF_FFF8);
    cycle(1, 0, 0, 32'h0, 0, 1);
    cycle(1, 0, 0, 32'h0, 0, 1);
    check("wrap_b_fffc", pc_b, 32'hFFFF_FFFC);
    cycle(1, 0, 0, 32'h0, 0, 1);
    check("seq_pc_a_8", pc_a, 32'h8);
    check("wrap_b_zero", pc_b, 32'h0);

    // Taken branch with memory ready: immediate redirect.
    cycle(1, 1, 1, 32'h100, 0, 1);
    check("redirect_pc", pc_a, 32'h100);

    // Back to 8, then taken branch with memory busy for three cycles.
    cycle(0, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 32'h0, 0, 1);
    cycle(1, 1, 1, 32'h100, 0, 0);
    cycle(1, 1, 1, 32'h200, 1, 0);
    cycle(1, 0, 0, 32'h300, 0, 0);
    check("pend_hold_pc", pc_a, 32'h8);
    cycle(1, 0, 0, 32'h0, 0, 1);
    check("pend_exit_pc", pc_a, 32'h100);

    // Stall masks a taken branch for two cycles, then the redirect happens.
    cycle(1, 1, 1, 32'h400, 1, 1);
    cycle(1, 1, 1, 32'h400, 1, 1);
    check("stall_hold_pc", pc_a, 32'h100);
    cycle(1, 1, 1, 32'h400, 0, 1);
    check("post_stall_pc", pc_a, 32'h400);

    // Misaligned target is word aligned.
    cycle(1, 1, 1, 32'h103, 0, 1);
    check("align_pc", pc_a, 32'h100);

    // Reset while parked in PEND: pending target must never land.
    cycle(1, 1, 1, 32'h800, 0, 0);
    cycle(0, 0, 0, 32'h0, 0, 0);
    check("rst_pend_pc", pc_a, 32'h0);
    check("rst_pend_rp", {31'b0, rp_a}, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 32'h0, 0, 1);
    check("no_stale_target", pc_a, 32'h8);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 79) != 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0),
            $urandom(),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Time limit so the run always terminates.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Fetch-stage PC owner and branch-redirect controller for the 5-stage MIPS pipeline. Consumes the ID-stage `comparator` result (`branch`) plus the ID-computed target, and acts on it: redirects the PC, flushes IF/ID, and holds a redirect while instruction memory is busy. Sits between the hazard unit, the ID-stage comparator, and the instruction-memory fetch port.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `CNT_WIDTH`, default 16: width of the branch statistics counters.

- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `branch`  in  1: comparator output; branch taken in ID.
- `br_inst`  in  1: ID holds a BEQ/BNE (`BEQ|BNE`). `branch=1` implies `br_inst=1`.
- `target`  in  32: branch target computed in ID.
- `stall`  in  1: load-use stall from the hazard unit.
- `imem_ready`  in  1: instruction memory accepts/completes the fetch at `pc` this cycle.
- `pc`  out  32: fetch address, registered.
- `fetch_valid`  out  1: `pc` is a valid fetch request, registered.
- `flush_ifid`  out  1: clear IF/ID at this clock edge. Combinational from state and inputs.
- `redirect_pending`  out  1: high in state PEND.
- `br_count`  out  CNT_WIDTH: resolved branches (see Configuration).
- `taken_count`  out  CNT_WIDTH: taken redirects (see Configuration).

## Operation
- States: IDLE, RUN, PEND.
- Reset (`rst_n=0` at an edge):
  - state=IDLE, `pc`=RESET_PC, `fetch_valid`=0, `redirect_pending`=0, pending target=0, counters=0.
  - `flush_ifid`=0 while in IDLE.
- IDLE: unconditionally goes to RUN at the next edge. `fetch_valid`=1 from then on.
- RUN, evaluated in priority order:
  1. `stall=1`: `pc` held. `branch` and `br_inst` are ignored, because operands are not resolved.
  2. `branch=1`, `stall=0`: `flush_ifid`=1 this cycle.
     - If `imem_ready=1`: `pc` <= {`target`[31:2],2'b00}.
     - If `imem_ready=0`: pending target <= {`target`[31:2],2'b00}, `pc` held, next state=PEND.
  3. `imem_ready=1`: `pc` <= `pc`+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  4. Otherwise: `pc` held.
- PEND:
  - `pc` and `fetch_valid` stay stable. The handshake rule is that the address must not change while valid and not ready.
  - `branch`, `br_inst` and `stall` are ignored. ID holds a flushed bubble.
  - On `imem_ready=1`: `pc` <= pending target, `flush_ifid`=1 to discard the completed wrong-path fetch, next state=RUN.
- Target bits [1:0] are always forced to 0. No exception is raised for misalignment.
- Reset during PEND discards the pending target. The first fetch after reset is RESET_PC.

## Timing
- Redirect latency: a taken branch with `imem_ready=1` produces the new `pc` at the next edge, giving 1 wrong-path slot, which is flushed the same cycle.
- With `imem_ready` low for N cycles, `pc` changes at the edge after `imem_ready` returns high.
- `flush_ifid` is a single-cycle pulse per event: one in RUN on the branch, and one more on PEND exit.
- No combinational path from `imem_ready` to `pc`. Paths to `flush_ifid` are allowed.

## Configuration
- `BRANCH_STATS_EN` defined:
  - `br_count` +1 on each RUN cycle with `br_inst=1` and `stall=0`.
  - `taken_count` +1 on each RUN cycle with `branch=1` and `stall=0`.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: both ports remain present and are tied to 0. No counter flops are built.

## Structure
- Shared package/include `pc_ctrl_pkg` holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, PEND=2'd2);
  - PC_STEP=4;
  - the default RESET_PC.
- One sub-module, `sat_counter` (parameter WIDTH; inputs clk, rst_n, inc; output count). It is instantiated twice under `BRANCH_STATS_EN`.

## Test plan
- Reset, release, 3 cycles with `imem_ready=1`:
  - `pc`=0 in IDLE with `fetch_valid`=0;
  - then `pc`=0,4,8 with `fetch_valid`=1.
- At `pc`=8, drive `branch=1`, `target`=32'h100, `imem_ready=1`:
  - `flush_ifid`=1 that cycle;
  - `pc`=32'h100 next;
  - `taken_count`=1.
- Same as the previous scenario with `imem_ready=0` for 3 cycles:
  - `redirect_pending`=1 and `pc` held at 8;
  - on ready, `flush_ifid`=1 and then `pc`=32'h100.
- `stall=1` with `branch=1` for 2 cycles:
  - `pc` held, `flush_ifid`=0, counters unchanged;
  - after `stall` drops, the redirect occurs.
- `target`=32'h103:
  - `pc`=32'h100.
- RESET_PC=32'hFFFF_FFF8:
  - `pc`=FFFF_FFF8, FFFF_FFFC, then 0.
- Reset asserted during PEND:
  - `pc`=RESET_PC, `redirect_pending`=0, and the pending target is never applied.
